// File: rtl/psec5_spi_pkg.sv
// Shared types and constants for the PSEC5 SPI host sequencer.
// Register map addresses match the on-chip slave decode.
package psec5_spi_pkg;

  typedef enum logic [2:0] {
    ST_CHIP_RST,
    ST_IDLE,
    ST_BIT_LA,
    ST_BIT_HI,
    ST_BIT_LB,
    ST_FETCH,
    ST_ICLK_HI,
    ST_ICLK_LO
  } seq_state_t;

  localparam int BYTE_BITS         = 8;
  localparam int ICLK_RESET_PULSES = 8;

  localparam logic [7:0] PSEC5_ADDR_TCM      = 8'd1;
  localparam logic [7:0] PSEC5_ADDR_INST     = 8'd2;
  localparam logic [7:0] PSEC5_ADDR_MODE     = 8'd3;
  localparam logic [7:0] PSEC5_ADDR_RD_FIRST = 8'd4;
  localparam logic [7:0] PSEC5_ADDR_RD_LAST  = 8'd59;

endpackage

// File: rtl/psec5_phase_timer.sv
// Half-phase timer: restart loads HALF_DIV-1, expire pulses once on the
// last cycle of the phase. Shared by the sclk bit phases and iclk pulses.
module psec5_phase_timer #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expire
);

  localparam int CW = $clog2(HALF_DIV);

  logic [CW-1:0] cnt_reg;
  logic          run_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (restart) begin
      cnt_reg <= CW'(HALF_DIV - 1);
      run_reg <= 1'b1;
    end else if (run_reg) begin
      if (cnt_reg == '0) run_reg <= 1'b0;
      else               cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign expire = run_reg && (cnt_reg == '0);

endmodule

// File: rtl/psec5_spi_sequencer.sv
// Host-side master for the PSEC5 SPI slave: address byte, cmd_len full-duplex
// data bytes, then an 8-pulse iclk frame reset. All chip pins come from flops.
module psec5_spi_sequencer
  import psec5_spi_pkg::*;
#(
  parameter int HALF_DIV = 4,
  parameter int LEN_W    = 6,
  parameter int RST_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             iclk,
  output logic             serial_in,
  input  logic             serial_out,
  output logic             chip_rstn
);

  localparam int RW = $clog2(RST_HOLD + 1);

  seq_state_t       state_reg, state_next;
  logic [7:0]       tx_reg, tx_next, rx_reg, rd_data_reg;
  logic [2:0]       bit_cnt_reg, pulse_cnt_reg;
  logic [LEN_W-1:0] bytes_left_reg;
  logic [RW-1:0]    rst_cnt_reg;
  logic             addr_byte_reg, so_meta_reg, so_sync_reg;
  logic             sclk_reg, iclk_reg, serial_in_reg, chip_rstn_reg;
  logic             rd_valid_reg, done_reg;
  logic             expire, accept, wr_take, bit_end, byte_end;

  // Every timed phase is entered through a state change, so that alone restarts the timer.
  psec5_phase_timer #(.HALF_DIV(HALF_DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (state_next != state_reg),
    .expire  (expire)
  );

  assign accept   = (state_reg == ST_IDLE) && cmd_valid;
  assign wr_take  = (state_reg == ST_FETCH) && wr_valid;
  assign bit_end  = (state_reg == ST_BIT_LB) && expire;
  assign byte_end = bit_end && (bit_cnt_reg == 3'(BYTE_BITS - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CHIP_RST: if (rst_cnt_reg == RW'(RST_HOLD)) state_next = ST_IDLE;
      ST_IDLE:     if (cmd_valid) state_next = ST_BIT_LA;
      ST_BIT_LA:   if (expire) state_next = ST_BIT_HI;
      ST_BIT_HI:   if (expire) state_next = ST_BIT_LB;
      ST_BIT_LB: begin
        if (expire) begin
          if (!byte_end)                 state_next = ST_BIT_LA;
          else if (bytes_left_reg != '0) state_next = ST_FETCH;
          else                           state_next = ST_ICLK_HI;
        end
      end
      ST_FETCH:    if (wr_valid) state_next = ST_BIT_LA;
      ST_ICLK_HI:  if (expire) state_next = ST_ICLK_LO;
      ST_ICLK_LO: begin
        if (expire)
          state_next = (pulse_cnt_reg == 3'(ICLK_RESET_PULSES - 1)) ? ST_IDLE : ST_ICLK_HI;
      end
      default:     state_next = ST_CHIP_RST;
    endcase
  end

  always_comb begin
    tx_next = tx_reg;
    if (accept)       tx_next = cmd_addr;
    else if (wr_take) tx_next = wr_data;
    else if (bit_end) tx_next = {tx_reg[6:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_CHIP_RST;
      tx_reg         <= '0;
      rx_reg         <= '0;
      rd_data_reg    <= '0;
      bit_cnt_reg    <= '0;
      pulse_cnt_reg  <= '0;
      bytes_left_reg <= '0;
      rst_cnt_reg    <= '0;
      addr_byte_reg  <= 1'b0;
      so_meta_reg    <= 1'b0;
      so_sync_reg    <= 1'b0;
      sclk_reg       <= 1'b0;
      iclk_reg       <= 1'b0;
      serial_in_reg  <= 1'b0;
      chip_rstn_reg  <= 1'b0;
      rd_valid_reg   <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tx_reg      <= tx_next;
      so_meta_reg <= serial_out;
      so_sync_reg <= so_meta_reg;
      // Pin levels are registered decodes of the next state, so they never glitch.
      sclk_reg    <= (state_next == ST_BIT_HI);
      iclk_reg    <= (state_next == ST_ICLK_HI);

      if ((state_next == ST_BIT_LA) && (state_reg != ST_BIT_LA))
        serial_in_reg <= tx_next[7];
      else if (state_next inside {ST_ICLK_HI, ST_ICLK_LO, ST_IDLE})
        serial_in_reg <= 1'b0;

      if (state_reg == ST_CHIP_RST) begin
        if (rst_cnt_reg != RW'(RST_HOLD))     rst_cnt_reg   <= rst_cnt_reg + 1'b1;
        if (rst_cnt_reg == RW'(RST_HOLD - 1)) chip_rstn_reg <= 1'b1;
      end

      if (accept) begin
        bytes_left_reg <= cmd_len;
        addr_byte_reg  <= 1'b1;
        bit_cnt_reg    <= '0;
        pulse_cnt_reg  <= '0;
      end
      if (wr_take) bytes_left_reg <= bytes_left_reg - 1'b1;

      if (bit_end) begin
        rx_reg      <= {rx_reg[6:0], so_sync_reg};
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
        if (byte_end) addr_byte_reg <= 1'b0;
      end
      rd_valid_reg <= byte_end && !addr_byte_reg;
      if (byte_end && !addr_byte_reg) rd_data_reg <= {rx_reg[6:0], so_sync_reg};

      if ((state_reg == ST_ICLK_LO) && expire) pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
      done_reg <= (state_reg == ST_ICLK_LO) && (state_next == ST_IDLE);
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign wr_ready  = wr_take;
  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;
  assign done      = done_reg;
  assign sclk      = sclk_reg;
  assign iclk      = iclk_reg;
  assign serial_in = serial_in_reg;
  assign chip_rstn = chip_rstn_reg;

endmodule

// File: tb/tb_psec5_spi_sequencer.sv
// Bench for psec5_spi_sequencer: pin-level PSEC5 slave model plus a
// transaction-level register-map reference; directed and random frames.
module tb_psec5_spi_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_addr = 8'h00;
  logic [5:0] cmd_len = 6'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, busy, done, sclk, iclk, serial_in, chip_rstn;
  logic       serial_out = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  psec5_spi_sequencer #(.HALF_DIV(4), .LEN_W(6), .RST_HOLD(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .done(done), .sclk(sclk), .iclk(iclk), .serial_in(serial_in),
    .serial_out(serial_out), .chip_rstn(chip_rstn)
  );

  // Pin-level slave: shifts serial_in on sclk rise, drives readback on sclk fall,
  // writes each data byte at its end, and drops framing on any iclk pulse.
  logic [7:0] chip_mem [256];
  logic [7:0] chip_addr = 8'h00, chip_sh = 8'h00, chip_rb = 8'h00, chip_idx;
  int         chip_bit = 0, chip_byte = 0, chip_oidx = 0;
  logic       csclk_q = 1'b0, ciclk_q = 1'b0;

  always @(negedge clk) begin
    if (chip_rstn !== 1'b1) begin
      for (int i = 0; i < 256; i++) chip_mem[i] = 8'h00;
      chip_bit = 0; chip_byte = 0; chip_addr = 8'h00; serial_out = 1'b0;
    end else begin
      if (iclk && !ciclk_q) begin chip_bit = 0; chip_byte = 0; end
      if (sclk && !csclk_q) begin
        if (chip_bit == 0) begin
          chip_idx = chip_addr + 8'(chip_byte) - 8'd1;
          chip_rb  = (chip_byte == 0) ? 8'h00 : chip_mem[chip_idx];
        end
        chip_oidx = 7 - chip_bit;
        chip_sh   = {chip_sh[6:0], serial_in};
        chip_bit++;
        if (chip_bit == 8) begin
          if (chip_byte == 0) chip_addr = chip_sh;
          else begin
            chip_idx = chip_addr + 8'(chip_byte) - 8'd1;
            chip_mem[chip_idx] = chip_sh;
          end
          chip_byte++;
          chip_bit = 0;
        end
      end
      if (!sclk && csclk_q) serial_out = chip_rb[chip_oidx];
    end
    csclk_q = sclk;
    ciclk_q = iclk;
  end

  // Transaction-level reference: register map contents seen by the host.
  logic [7:0] ref_mem [256];
  logic [7:0] wdat [64];
  logic [7:0] exp_rd[$];
  logic [7:0] got_rd[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    int cnt;
    rst = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 0);           check("rst_iclk", iclk, 0);
    check("rst_serial_in", serial_in, 0); check("rst_cmd_ready", cmd_ready, 0);
    check("rst_wr_ready", wr_ready, 0);   check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);           check("rst_busy", busy, 1);
    check("rst_rd_data", rd_data, 0);     check("rst_chip_rstn", chip_rstn, 0);
    rst = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (chip_rstn !== 1'b1 && cnt < 200);
    check("rstn_low_cycles", cnt, 16);
    check("cmd_ready_with_rstn", cmd_ready, 0);
    @(negedge clk);
    check("cmd_ready_rise", cmd_ready, 1);
    check("idle_sclk_iclk", {sclk, iclk}, 0);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    $display("reset: chip_rstn low %0d cycles", cnt);
  endtask

  // One command frame. stall_at: data byte index before which wr_valid is withheld
  // for stall_len cycles; abort_at: data byte index during whose BIT_HI rst is raised.
  task automatic run_frame(input logic [7:0] addr, input int len, input int stall_at,
                           input int stall_len, input int abort_at);
    int n_sclk, n_iclk, n_done, n_busy, wi, hold, overlap, si_bad, stall_bad, cyc;
    logic sclk_p, iclk_p, si_hold, withhold, aborted;
    exp_rd.delete(); got_rd.delete();
    for (int k = 0; k < len; k++) exp_rd.push_back(ref_mem[8'(addr + 8'(k))]);
    n_sclk = 0; n_iclk = 0; n_done = 0; n_busy = 0; wi = 0; hold = 0;
    overlap = 0; si_bad = 0; stall_bad = 0; sclk_p = 0; iclk_p = 0;
    si_hold = 0; aborted = 0;
    @(negedge clk);
    check("cmd_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = 6'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (cyc = 0; cyc < 20000; cyc++) begin
      if (rd_valid) got_rd.push_back(rd_data);
      if (done) n_done++;
      if (sclk && !sclk_p) n_sclk++;
      if (iclk && !iclk_p) n_iclk++;
      if (sclk && iclk) overlap++;
      if (iclk && serial_in) si_bad++;
      sclk_p = sclk; iclk_p = iclk;
      if (!busy) break;
      n_busy++;
      if (abort_at >= 0 && sclk && n_sclk == 8 * (abort_at + 1) + 4) begin
        rst = 1'b1; aborted = 1'b1; break;
      end
      withhold = 1'b0;
      if (wi == stall_at && hold < stall_len && n_sclk >= 8 * (wi + 1)) begin
        withhold = 1'b1;
        hold++;
        if (hold == 12) si_hold = serial_in;
        if (hold > 12 && (sclk || serial_in !== si_hold)) stall_bad++;
      end
      wr_valid = (wi < len) && !withhold;
      wr_data  = (wi < len) ? wdat[wi] : 8'h00;
      #1;
      if (wr_ready) wi++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    if (cyc >= 20000) check("frame_timeout", cyc, 0);
    if (aborted) begin
      @(negedge clk);
      check("abort_sclk", sclk, 0);        check("abort_busy", busy, 1);
      check("abort_chip_rstn", chip_rstn, 0);
      check("abort_done", done, 0);        check("abort_rd_valid", rd_valid, 0);
      check("abort_rd_count", got_rd.size(), abort_at);
      check("abort_done_count", n_done, 0);
      $display("frame addr=0x%02h len=%0d aborted after %0d sclk rises", addr, len, n_sclk);
      return;
    end
    check("done_count", n_done, 1);
    check("cmd_ready_at_done", cmd_ready, 1);
    check("iclk_pulses", n_iclk, 8);
    check("sclk_rises", n_sclk, 8 * (len + 1));
    check("sclk_iclk_overlap", overlap, 0);
    check("serial_in_in_iclk", si_bad, 0);
    check("rd_count", got_rd.size(), len);
    for (int k = 0; k < len && k < got_rd.size(); k++)
      check($sformatf("rd_data[%0d]", k), got_rd[k], exp_rd[k]);
    if (stall_len == 0) check("frame_cycles", n_busy, 96 * (len + 1) + len + 64);
    else                check("stall_quiet", stall_bad, 0);
    for (int k = 0; k < len; k++) ref_mem[8'(addr + 8'(k))] = wdat[k];
    for (int k = 0; k < len; k++)
      check($sformatf("chip_reg[0x%02h]", 8'(addr + 8'(k))), chip_mem[8'(addr + 8'(k))],
            ref_mem[8'(addr + 8'(k))]);
    check("chip_addr", chip_addr, addr);
    repeat (3) @(negedge clk);
    if (len > 0) check("rd_data_held", rd_data, exp_rd[len - 1]);
    $display("frame addr=0x%02h len=%0d busy_cycles=%0d sclk=%0d rd=%0d", addr, len, n_busy,
             n_sclk, got_rd.size());
  endtask

  initial begin
    logic [7:0] a;
    int l;
    do_reset();
    // Configuration write, then readback of the same registers.
    wdat[0] = 8'h29; wdat[1] = 8'h06; wdat[2] = 8'h04;
    run_frame(8'h01, 3, -1, 0, -1);
    run_frame(8'h01, 3, -1, 0, -1);
    // Host stalls before the second data byte.
    wdat[0] = 8'h5A; wdat[1] = 8'hC3; wdat[2] = 8'h81;
    run_frame(8'h01, 3, 1, 62, -1);
    // Address-only frame.
    run_frame(8'h04, 0, -1, 0, -1);
    // Reset in the middle of data byte 2, then a clean write.
    wdat[0] = 8'hAA; wdat[1] = 8'h55; wdat[2] = 8'hF0;
    run_frame(8'h01, 3, -1, 0, 1);
    do_reset();
    wdat[0] = 8'h29; wdat[1] = 8'h06; wdat[2] = 8'h04;
    run_frame(8'h01, 3, -1, 0, -1);
    // Random frames, including address wrap and a long burst.
    for (int f = 0; f < 8; f++) begin
      a = 8'($urandom_range(0, 255));
      l = (f == 7) ? 20 : int'($urandom_range(0, 6));
      for (int k = 0; k < l; k++) wdat[k] = 8'($urandom);
      run_frame(a, l, (f == 3) ? 0 : -1, (f == 3) ? 40 : 0, -1);
      run_frame(a, l, -1, 0, -1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
